// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: op enum, MIPS opcode/funct codes,
// field positions and the combinational encode function.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_JR, OP_JALR,
        OP_LW, OP_LBU, OP_SW, OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU,
        OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_NOP
    } op_e;

    typedef enum logic {ST_IDLE, ST_PAD} pad_state_e;

    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned SH_LSB  = 6;
    localparam int unsigned FN_LSB  = 0;

    localparam logic [31:0] NOP_WORD = '0;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    localparam logic [5:0] OPC_J    = 6'h02, OPC_JAL  = 6'h03, OPC_BEQ  = 6'h04, OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0A, OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI = 6'h0C, OPC_ORI  = 6'h0D, OPC_LUI  = 6'h0F;
    localparam logic [5:0] OPC_LW   = 6'h23, OPC_LBU  = 6'h24, OPC_SW   = 6'h2B;

    function automatic logic isIllegalOp(input logic [4:0] op);
        return op >= 5'd30;
    endfunction

    function automatic logic isDelaySlotOp(input logic [4:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR, OP_JALR};
    endfunction

    function automatic logic [31:0] rWord(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        logic [31:0] w;
        w = '0;
        w[RS_LSB +: 5] = rs;
        w[RT_LSB +: 5] = rt;
        w[RD_LSB +: 5] = rd;
        w[SH_LSB +: 5] = sh;
        w[FN_LSB +: 6] = fn;
        return w;
    endfunction

    function automatic logic [31:0] iWord(input logic [5:0] opc, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: 6] = opc;
        w[RS_LSB +: 5]  = rs;
        w[RT_LSB +: 5]  = rt;
        w[15:0]         = imm;
        return w;
    endfunction

    function automatic logic [31:0] jWord(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

    // Fields an op does not use are passed as zero so stray request bits never leak into the word.
    function automatic logic [31:0] encodeInstr(input logic [4:0] op, input logic [4:0] rs, rt, rd, shamt,
                                                input logic [15:0] imm, input logic [25:0] target);
        logic [31:0] w;
        w = NOP_WORD;
        case (op)
            OP_ADD:   w = rWord(rs, rt, rd, 5'd0, FN_ADD);
            OP_ADDU:  w = rWord(rs, rt, rd, 5'd0, FN_ADDU);
            OP_SUB:   w = rWord(rs, rt, rd, 5'd0, FN_SUB);
            OP_SUBU:  w = rWord(rs, rt, rd, 5'd0, FN_SUBU);
            OP_AND:   w = rWord(rs, rt, rd, 5'd0, FN_AND);
            OP_OR:    w = rWord(rs, rt, rd, 5'd0, FN_OR);
            OP_XOR:   w = rWord(rs, rt, rd, 5'd0, FN_XOR);
            OP_NOR:   w = rWord(rs, rt, rd, 5'd0, FN_NOR);
            OP_SLT:   w = rWord(rs, rt, rd, 5'd0, FN_SLT);
            OP_SLTU:  w = rWord(rs, rt, rd, 5'd0, FN_SLTU);
            OP_SLL:   w = rWord(5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:   w = rWord(5'd0, rt, rd, shamt, FN_SRL);
            OP_SRA:   w = rWord(5'd0, rt, rd, shamt, FN_SRA);
            OP_JR:    w = rWord(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_JALR:  w = rWord(rs, 5'd0, rd, 5'd0, FN_JALR);
            OP_LW:    w = iWord(OPC_LW, rs, rt, imm);
            OP_LBU:   w = iWord(OPC_LBU, rs, rt, imm);
            OP_SW:    w = iWord(OPC_SW, rs, rt, imm);
            OP_LUI:   w = iWord(OPC_LUI, 5'd0, rt, imm);
            OP_ADDI:  w = iWord(OPC_ADDI, rs, rt, imm);
            OP_ADDIU: w = iWord(OPC_ADDIU, rs, rt, imm);
            OP_ANDI:  w = iWord(OPC_ANDI, rs, rt, imm);
            OP_ORI:   w = iWord(OPC_ORI, rs, rt, imm);
            OP_SLTI:  w = iWord(OPC_SLTI, rs, rt, imm);
            OP_SLTIU: w = iWord(OPC_SLTIU, rs, rt, imm);
            OP_BEQ:   w = iWord(OPC_BEQ, rs, rt, imm);
            OP_BNE:   w = iWord(OPC_BNE, rs, rt, imm);
            OP_J:     w = jWord(OPC_J, target);
            OP_JAL:   w = jWord(OPC_JAL, target);
            default:  w = NOP_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is held in a register so the
// memory write port sees a stable value while the consumer stalls.
module instr_enc_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      count;
    logic             doPush, doPop;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            headData <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // Next head comes from memory, or straight from the push when the FIFO is about to run dry.
            if (doPop) begin
                if (count > CNT_ONE) headData <= mem[rdPtr + PTR_ONE];
                else if (doPush)     headData <= pushData;
            end else if (empty && doPush) begin
                headData <= pushData;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes abstract instruction requests into MIPS words, buffers them and writes them to imem.
// Optional macro INSTR_ENC_DELAY_SLOT_EN appends a NOP after every branch/jump.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_start,
    input  logic [ADDR_WIDTH-1:0] prog_base,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            req_op,
    input  logic [4:0]            req_rs,
    input  logic [4:0]            req_rt,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_shamt,
    input  logic [15:0]           req_imm,
    input  logic [25:0]           req_target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    input  logic                  imem_ready,
    output logic                  busy,
    output logic [15:0]           word_count,
    output logic                  err_illegal
);
    logic                  fifoFull, fifoEmpty;
    logic                  pushEn, popEn, accept, illegal;
    logic [31:0]           pushData, headWord, encoded;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           wordCount;
    logic                  errIllegal;

    assign illegal = isIllegalOp(req_op);
    assign encoded = encodeInstr(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);
    assign popEn   = !fifoEmpty && imem_ready;

`ifdef INSTR_ENC_DELAY_SLOT_EN
    pad_state_e padState;

    assign req_ready = !fifoFull && (padState == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign pushEn    = (padState == ST_PAD) ? !fifoFull : (accept && !illegal);
    assign pushData  = (padState == ST_PAD) ? NOP_WORD : encoded;

    always_ff @(posedge clk) begin
        if (reset) begin
            padState <= ST_IDLE;
        end else begin
            case (padState)
                ST_IDLE: if (accept && !illegal && isDelaySlotOp(req_op)) padState <= ST_PAD;
                ST_PAD:  if (!fifoFull) padState <= ST_IDLE;
                default: padState <= ST_IDLE;
            endcase
        end
    end
`else
    assign req_ready = !fifoFull;
    assign accept    = req_valid && req_ready;
    assign pushEn    = accept && !illegal;
    assign pushData  = encoded;
`endif

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (pushEn),
        .pushData (pushData),
        .pop      (popEn),
        .headData (headWord),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // prog_start wins over a same-cycle pop: that write lands at the old address, the next at the base.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            wordCount  <= '0;
            errIllegal <= 1'b0;
        end else begin
            if (prog_start) begin
                addr      <= prog_base & ~ADDR_WIDTH'(3);
                wordCount <= '0;
            end else if (popEn) begin
                addr      <= addr + ADDR_WIDTH'(4);
                wordCount <= wordCount + 16'd1;
            end
            if (prog_start)            errIllegal <= 1'b0;
            else if (accept && illegal) errIllegal <= 1'b1;
        end
    end

    assign imem_we     = !fifoEmpty;
    assign imem_addr   = addr;
    assign imem_wdata  = headWord;
    assign busy        = !fifoEmpty;
    assign word_count  = wordCount;
    assign err_illegal = errIllegal;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues expected words, monitor checks imem writes.
module tb_instr_encoder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          reset, prog_start, req_valid, req_ready;
    logic [AW-1:0] prog_base;
    logic [4:0]    req_op, req_rs, req_rt, req_rd, req_shamt;
    logic [15:0]   req_imm;
    logic [25:0]   req_target;
    logic          imem_we, imem_ready, busy, err_illegal;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [15:0]   word_count;

    int unsigned checks = 0, passes = 0;
    logic [31:0] expQ[$];
    logic [31:0] expAddr = '0;
    logic [15:0] expCount = '0;
    int          readyMode = 1;
    bit          sawIllegal = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .prog_start(prog_start), .prog_base(prog_base),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rs(req_rs),
        .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt), .req_imm(req_imm),
        .req_target(req_target), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy),
        .word_count(word_count), .err_illegal(err_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Table-driven model of the MIPS subset, indexed by op number.
    function automatic logic [31:0] refEncode(input int unsigned op, rs, rt, rd, sh, imm, tgt);
        int unsigned rFn[10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
        int unsigned sFn[3]  = '{0, 2, 3};
        int unsigned iOp[12] = '{35, 36, 43, 15, 8, 9, 12, 13, 10, 11, 4, 5};
        int unsigned jOp[2]  = '{2, 3};
        int unsigned w;
        if (op < 10)       w = rs * 2097152 + rt * 65536 + rd * 2048 + rFn[op];
        else if (op < 13)  w = rt * 65536 + rd * 2048 + sh * 64 + sFn[op - 10];
        else if (op == 13) w = rs * 2097152 + 8;
        else if (op == 14) w = rs * 2097152 + rd * 2048 + 9;
        else if (op < 27) begin
            w = iOp[op - 15] * 67108864 + rt * 65536 + imm;
            if (op != 18) w = w + rs * 2097152;
        end
        else if (op < 29)  w = jOp[op - 27] * 67108864 + tgt;
        else               w = 0;
        return w;
    endfunction

    function automatic bit isBranch(input int unsigned op);
        return op inside {13, 14, 25, 26, 27, 28};
    endfunction

    initial begin
        imem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            imem_ready = (readyMode == 2) ? 1'($urandom_range(0, 1)) : (readyMode == 1);
        end
    end

    // Monitor: a transfer is imem_we & imem_ready seen mid-cycle, committed at the next edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                expQ.delete();
                expAddr  = '0;
                expCount = '0;
            end else begin
                if (imem_we && imem_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
                    end else begin
                        e = expQ.pop_front();
                        check("wdata", imem_wdata, e);
                        check("addr", imem_addr, expAddr);
                        check("word_count", 32'(word_count), 32'(expCount));
                        expAddr  = expAddr + 32'd4;
                        expCount = expCount + 16'd1;
                    end
                end
                if (prog_start) begin
                    expAddr  = prog_base & 32'hFFFF_FFFC;
                    expCount = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic progStart(input logic [31:0] base);
        prog_base  = base;
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        sawIllegal = 0;
    endtask

    task automatic sendReq(input logic [4:0] op, rs, rt, rd, sh, input logic [15:0] imm,
                           input logic [25:0] tgt, input bit useFixed, input logic [31:0] fixed);
        bit accepted = 0;
        int n = 0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
        req_imm = imm; req_target = tgt; req_valid = 1'b1;
        while (!accepted && n < 100) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1;
                if (op >= 5'd30) sawIllegal = 1;
                else begin
                    expQ.push_back(useFixed ? fixed :
                        refEncode(32'(op), 32'(rs), 32'(rt), 32'(rd), 32'(sh), 32'(imm), 32'(tgt)));
`ifdef INSTR_ENC_DELAY_SLOT_EN
                    if (isBranch(32'(op))) expQ.push_back(32'h0);
`endif
                end
            end
            tick();
            n++;
        end
        req_valid = 1'b0;
        if (!accepted) begin
            checks++;
            $display("FAIL req_timeout: got req_ready low for %0d cycles expected acceptance", n);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((busy || expQ.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", expQ.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; prog_start = 1'b0; prog_base = '0; req_valid = 1'b0;
        req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
        req_imm = '0; req_target = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        tick();
        reset = 1'b0;

        // Directed encodings with stray bits in unused fields.
        progStart(32'h0040_0000);
        sendReq(5'd19, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1, 32'h2008_0005);
        waitDrain();
        @(negedge clk);
        check("t1_word_count", 32'(word_count), 32'd1);
        tick();
        sendReq(5'd10, 5'd7, 5'd3, 5'd2, 5'd4, 16'hABCD, 26'h1234, 1, 32'h0003_1100);
        sendReq(5'd13, 5'd31, 5'd5, 5'd6, 5'd3, 16'h1111, 26'h55, 1, 32'h03E0_0008);
        sendReq(5'd15, 5'd29, 5'd9, 5'd0, 5'd0, 16'd4, 26'd0, 1, 32'h8FA9_0004);
        sendReq(5'd25, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1, 32'h1022_FFFF);
        sendReq(5'd27, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000, 1, 32'h0810_0000);
        waitDrain();

        // Stall: fill FIFO, verify backpressure and stable write port, then release.
        readyMode = 0;
        for (int i = 0; i < int'(DEPTH); i++)
            sendReq(5'd19, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i + 100), 26'd0, 0, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_we", 32'(imem_we), 32'd1);
            check("stall_addr", imem_addr, expAddr);
            check("stall_wdata", imem_wdata, expQ[0]);
            tick();
        end
        readyMode = 1;
        sendReq(5'd19, 5'd1, 5'd2, 5'd0, 5'd0, 16'd999, 26'd0, 0, '0);
        waitDrain();

        // Illegal op is consumed silently and flagged until the next prog_start.
        sendReq(5'd31, 5'd1, 5'd2, 5'd3, 5'd4, 16'd5, 26'd6, 0, '0);
        tick();
        @(negedge clk);
        check("illegal_err", 32'(err_illegal), 32'd1);
        check("illegal_no_write", 32'(imem_we), 32'd0);
        tick();
        progStart(32'h0000_1003);
        @(negedge clk);
        check("progstart_err", 32'(err_illegal), 32'd0);
        check("progstart_count", 32'(word_count), 32'd0);
        tick();

        // Branch followed by addi; delay-slot builds hold off the second request one cycle.
        sendReq(5'd25, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'd0, 0, '0);
        @(negedge clk);
`ifdef INSTR_ENC_DELAY_SLOT_EN
        check("ready_after_branch", 32'(req_ready), 32'd0);
`else
        check("ready_after_branch", 32'(req_ready), 32'd1);
`endif
        tick();
        sendReq(5'd19, 5'd0, 5'd8, 5'd0, 5'd0, 16'd7, 26'd0, 0, '0);
        waitDrain();

        // Randomized traffic with random memory backpressure.
        readyMode = 2;
        for (int i = 0; i < 150; i++) begin
            sendReq(5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 16'($urandom), 26'($urandom), 0, '0);
            repeat ($urandom_range(0, 2)) tick();
        end
        readyMode = 1;
        waitDrain();
        @(negedge clk);
        check("rand_err", 32'(err_illegal), 32'(sawIllegal));
        check("rand_word_count", 32'(word_count), 32'(expCount));
        tick();

        // Reset with words queued: everything flushed, nothing written afterwards.
        readyMode = 0;
        for (int i = 0; i < 3; i++)
            sendReq(5'd20, 5'd1, 5'd1, 5'd0, 5'd0, 16'(i), 26'd0, 0, '0);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_addr", imem_addr, 32'd0);
        check("midrst_count", 32'(word_count), 32'd0);
        tick();
        reset = 1'b0;
        readyMode = 1;
        repeat (3) tick();
        @(negedge clk);
        check("postrst_we", 32'(imem_we), 32'd0);
        tick();
        sendReq(5'd22, 5'd4, 5'd5, 5'd0, 5'd0, 16'h00F0, 26'd0, 0, '0);
        waitDrain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
